// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - 8E1 UART receiver with centre sampling and parity/framing status
//
// Purpose:
//   Synchronises the asynchronous rx line, detects the start edge, samples
//   start/data/parity/stop at the bit centre and presents the byte with a
//   one-cycle valid strobe plus parity and framing status.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (even, 4..65535)
//
// Configuration macro:
//   RX_PARITY_CHECK_EN  defined: even parity is checked and reported on
//                       parity_err. Undefined: the parity bit time is still
//                       consumed but its value is ignored; parity_err is 0.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   rx          asynchronous serial input, idles high
//   rx_data     last received byte, held until the next frame completes
//   rx_valid    one-cycle strobe when a frame completes
//   parity_err  parity status of the last frame (qualified by rx_valid, held)
//   frame_err   stop bit sampled low in the last frame (qualified by rx_valid, held)
//   busy        high whenever the receiver is not idle

module uart_rx_controller #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_next;

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    rx_data_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          parity_calc;

  logic          half_hit;
  logic          bit_hit;
  logic          sample_bit;
  logic          sample_par;
  logic          done;

  // Two-flop synchroniser plus one history flop for edge detection. All
  // reset to the idle line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sample_bit = 1'b0;
    sample_par = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a line stuck low
        // (e.g. after a framing error) never retriggers.
        if (rx_prev && !rx_sync) begin
          state_next = START;
        end
      end
      START: begin
        // Re-check the start bit at its centre to reject glitches.
        if (half_hit) begin
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_hit) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_hit) begin
          sample_par = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        // Leave half a bit early so a back-to-back start edge is caught.
        if (bit_hit) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Because START ends at the half-bit point, every later N-cycle wrap
  // lands on a bit centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE || state_next != state || bit_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state == START && state_next == DATA) begin
        bit_idx <= 3'd0;
      end else if (sample_bit) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // LSB arrives first, so shifting right leaves it in bit 0 after 8 bits.
      if (sample_bit) begin
        shift_reg <= {rx_sync, shift_reg[7:1]};
      end
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (sample_par) begin
      par_bit <= rx_sync;
    end
  end

  assign parity_calc = ^{shift_reg, par_bit};
`else
  assign parity_calc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q    <= 8'h00;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (done) begin
      rx_data_q    <= shift_reg;
      parity_err_q <= parity_calc;
      frame_err_q  <= ~rx_sync;
    end
  end

  // The strobe fires in the stop-sample cycle itself; the byte and status
  // are bypassed to the outputs in that cycle and held by the registers
  // from the next cycle onward.
  assign rx_valid   = done;
  assign rx_data    = done ? shift_reg   : rx_data_q;
  assign parity_err = done ? parity_calc : parity_err_q;
  assign frame_err  = done ? ~rx_sync    : frame_err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - directed self-checking bench for uart_rx_controller

module tb_uart_rx_controller;

  localparam int N = 16;
  localparam int H = N / 2;
  // Cycles from the edge after which the start bit is driven to the stop-sample cycle.
  localparam int VALID_OFS = 2 + H + 10 * N;

`ifdef RX_PARITY_CHECK_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_checks;
  int n_pass;
  int cyc;
  int dbl_valid;
  logic prev_valid;
  logic busy_hist [8192];

  int         v_cyc  [$];
  logic [7:0] v_data [$];
  logic       v_perr [$];
  logic       v_ferr [$];

  uart_rx_controller #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and the busy level of every cycle, sampled mid-cycle.
  initial begin
    dbl_valid  = 0;
    prev_valid = 1'b0;
  end
  always @(negedge clk) begin
    if (cyc < 8192) busy_hist[cyc] = busy;
    if (rx_valid) begin
      v_cyc.push_back(cyc);
      v_data.push_back(rx_data);
      v_perr.push_back(parity_err);
      v_ferr.push_back(frame_err);
      if (prev_valid) dbl_valid = dbl_valid + 1;
    end
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with rx left at the stop level.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int e0);
    e0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int e0;
  int e1;
  int base;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    rx       = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(4);

    // Clean frame 0xA5, even parity 0, stop 1.
    base = v_cyc.size();
    send_frame(8'hA5, 1'b0, 1'b1, e0);
    idle(20);
    check("clean_count", v_cyc.size() - base, 1);
    check("clean_latency", v_cyc[base] - e0, VALID_OFS);
    check("clean_data", v_data[base], 8'hA5);
    check("clean_perr", v_perr[base], 1'b0);
    check("clean_ferr", v_ferr[base], 1'b0);
    check("clean_busy_start_m1", busy_hist[e0 + 2], 1'b0);
    check("clean_busy_start", busy_hist[e0 + 3], 1'b1);
    check("clean_busy_at_valid", busy_hist[e0 + VALID_OFS], 1'b1);
    check("clean_busy_after", busy_hist[e0 + VALID_OFS + 1], 1'b0);
    check("clean_data_held", rx_data, 8'hA5);

    // Parity error: 0x3C has even weight, so parity 1 is wrong.
    base = v_cyc.size();
    send_frame(8'h3C, 1'b1, 1'b1, e0);
    idle(20);
    check("par_count", v_cyc.size() - base, 1);
    check("par_data", v_data[base], 8'h3C);
    check("par_perr", v_perr[base], PAR_ON);
    check("par_ferr", v_ferr[base], 1'b0);
    check("par_perr_held", parity_err, PAR_ON);

    // Framing error: stop 0, then line held low for 3 more bit times.
    base = v_cyc.size();
    send_frame(8'h81, 1'b0, 1'b0, e0);
    idle(3 * N);
    check("frm_busy_low_line", busy, 1'b0);
    rx = 1'b1;
    idle(40);
    check("frm_count", v_cyc.size() - base, 1);
    check("frm_data", v_data[base], 8'h81);
    check("frm_ferr", v_ferr[base], 1'b1);
    check("frm_perr", v_perr[base], 1'b0);
    check("frm_ferr_held", frame_err, 1'b1);

    // Glitch: 4 low cycles; START gives up at its half-bit check.
    base = v_cyc.size();
    e1 = cyc;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("gl_busy_rise", busy_hist[e1 + 3], 1'b1);
    check("gl_busy_last", busy_hist[e1 + 2 + H], 1'b1);
    check("gl_busy_fall", busy_hist[e1 + 3 + H], 1'b0);
    check("gl_no_valid", v_cyc.size() - base, 0);
    check("gl_data_kept", rx_data, 8'h81);
    check("gl_ferr_kept", frame_err, 1'b1);

    // Reset in the middle of data bit 3 of 0x55.
    base = v_cyc.size();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    idle(H);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    idle(2 * N);
    send_frame(8'hF0, 1'b0, 1'b1, e0);
    idle(20);
    check("rst_count", v_cyc.size() - base, 1);
    check("rst_f0_data", v_data[base], 8'hF0);
    check("rst_f0_perr", v_perr[base], 1'b0);
    check("rst_f0_ferr", v_ferr[base], 1'b0);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    base = v_cyc.size();
    send_frame(8'h00, 1'b0, 1'b1, e0);
    send_frame(8'hFF, 1'b0, 1'b1, e1);
    idle(20);
    check("b2b_count", v_cyc.size() - base, 2);
    check("b2b_spacing", v_cyc[base + 1] - v_cyc[base], 11 * N);
    check("b2b_data0", v_data[base], 8'h00);
    check("b2b_data1", v_data[base + 1], 8'hFF);
    check("b2b_err0", {v_perr[base], v_ferr[base]}, 2'b00);
    check("b2b_err1", {v_perr[base + 1], v_ferr[base + 1]}, 2'b00);

    check("no_double_valid", dbl_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
